// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and defaults for the ALU command sequencer: FSM encoding and the
// command payload carried through the FIFO to the ALU.
package alu_op_sequencer_pkg;

  localparam int unsigned DATA_WIDTH             = 32;
  localparam int unsigned OP_WIDTH               = 8;
  localparam int unsigned DEPTH_DEFAULT          = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic [OP_WIDTH-1:0]   opcode;
  } cmd_t;

endpackage

// File: rtl/alu_op_sequencer_cmd_fifo.sv
// Command FIFO: registered level/empty/ready flags, combinational head read.
// ready_o is low during reset and while the FIFO is full.
module alu_op_sequencer_cmd_fifo
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  cmd_t                     wdata_i,
  output cmd_t                     rdata_c,
  output logic                     empty_o,
  output logic                     ready_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          empty_q;
  logic          ready_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && ready_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags are computed from the next count so they are valid right after each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      ready_q <= (count_d != (AW + 1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_c = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign ready_o = ready_q;
  assign level_o = count_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front-end for alu_top: queues commands, issues them one at a time on the
// op_valid/operation_done handshake, and returns each result (or a timeout) on rsp_*.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH          = DEPTH_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [DATA_WIDTH-1:0]   cmd_operand_a_i,
  input  logic [DATA_WIDTH-1:0]   cmd_operand_b_i,
  input  logic [OP_WIDTH-1:0]     cmd_operator_i,
  output logic                    op_valid_o,
  output logic [DATA_WIDTH-1:0]   operand_a_o,
  output logic [DATA_WIDTH-1:0]   operand_b_o,
  output logic [OP_WIDTH-1:0]     operator_o,
  input  logic                    operation_done_i,
  input  logic [DATA_WIDTH-1:0]   alu_result_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_result_o,
  output logic                    rsp_timeout_o,
  output logic [$clog2(DEPTH):0]  fifo_level_o
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e                state_q, state_d;
  logic                  op_valid_q, op_valid_d;
  logic [TW-1:0]         timer_q, timer_d;
  cmd_t                  cmd_q, cmd_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  cmd_t                  cmd_in;
  cmd_t                  fifo_head_c;
  logic                  fifo_empty;
  logic                  fifo_pop_c;

  assign cmd_in = '{operand_a: cmd_operand_a_i,
                    operand_b: cmd_operand_b_i,
                    opcode:    cmd_operator_i};

  alu_op_sequencer_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid_i),
    .pop_i   (fifo_pop_c),
    .wdata_i (cmd_in),
    .rdata_c (fifo_head_c),
    .empty_o (fifo_empty),
    .ready_o (cmd_ready_o),
    .level_o (fifo_level_o)
  );

  // Next-state and output logic; operation_done only counts while op_valid is high.
  always_comb begin
    state_d       = state_q;
    op_valid_d    = op_valid_q;
    timer_d       = timer_q;
    cmd_d         = cmd_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    fifo_pop_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop_c = 1'b1;
          cmd_d      = fifo_head_c;
          timer_d    = '0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Operands settle on the ALU inputs one cycle before op_valid rises.
        if (!op_valid_q) begin
          op_valid_d = 1'b1;
        end else if (operation_done_i) begin
          op_valid_d    = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_result_d  = alu_result_i;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          op_valid_d    = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        op_valid_d  = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_valid_q    <= 1'b0;
      timer_q       <= '0;
      cmd_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_valid_q    <= op_valid_d;
      timer_q       <= timer_d;
      cmd_q         <= cmd_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign op_valid_o    = op_valid_q;
  assign operand_a_o   = cmd_q.operand_a;
  assign operand_b_o   = cmd_q.operand_b;
  assign operator_o    = cmd_q.opcode;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_result_o  = rsp_result_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vector table, multi-cycle corner sequences,
// and random traffic checked against an in-order command/response model.
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_operand_a_i;
  logic [31:0] cmd_operand_b_i;
  logic [7:0]  cmd_operator_i;
  logic        op_valid_o;
  logic [31:0] operand_a_o;
  logic [31:0] operand_b_o;
  logic [7:0]  operator_o;
  logic        operation_done_i;
  logic [31:0] alu_result_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_timeout_o;
  logic [2:0]  fifo_level_o;

  alu_op_sequencer #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_ready_o      (cmd_ready_o),
    .cmd_operand_a_i  (cmd_operand_a_i),
    .cmd_operand_b_i  (cmd_operand_b_i),
    .cmd_operator_i   (cmd_operator_i),
    .op_valid_o       (op_valid_o),
    .operand_a_o      (operand_a_o),
    .operand_b_o      (operand_b_o),
    .operator_o       (operator_o),
    .operation_done_i (operation_done_i),
    .alu_result_i     (alu_result_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_result_o     (rsp_result_o),
    .rsp_timeout_o    (rsp_timeout_o),
    .fifo_level_o     (fifo_level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
    int          lat;
    logic [31:0] exp_res;
    logic        exp_tmo;
    int          exp_width;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
  } mcmd_t;

  vec_t  vecs [8];
  mcmd_t mq [$];

  // ALU behaviour used by both the ALU stand-in and the expectation model.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [7:0] op);
    case (op)
      8'h01:   return a + b;
      8'h02:   return a - b;
      8'h03:   return a & b;
      8'h04:   return a ^ b;
      default: return a | b;
    endcase
  endfunction

  // Random-phase latency derived from the operand; 0 means the ALU never completes.
  function automatic int lat_of(input logic [31:0] a);
    if (a[3:0] == 4'h0) return 0;
    return int'(a[1:0]) + 1;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ALU stand-in: completes after fixed_lat op_valid cycles (or per-operand latency).
  int   fixed_lat = 1;
  logic late_done = 1'b0;
  int   alu_cnt   = 0;
  int   alu_lat   = 0;
  initial begin
    operation_done_i = 1'b0;
    alu_result_i     = 32'h0;
  end
  always @(negedge clk) begin
    if (op_valid_o) begin
      alu_cnt          = alu_cnt + 1;
      alu_lat          = (fixed_lat >= 0) ? fixed_lat : lat_of(operand_a_o);
      operation_done_i = late_done || (alu_lat != 0 && alu_cnt >= alu_lat);
      alu_result_i     = alu_fn(operand_a_o, operand_b_o, operator_o);
    end else begin
      alu_cnt          = 0;
      operation_done_i = late_done;
      alu_result_i     = 32'hDEAD_BEEF;
    end
  end

  task automatic issue_one(input vec_t v);
    int w;
    fixed_lat   = v.lat;
    rsp_ready_i = 1'b0;
    chk1("cmd_ready_idle", cmd_ready_o, 1'b1);
    cmd_valid_i     = 1'b1;
    cmd_operand_a_i = v.a;
    cmd_operand_b_i = v.b;
    cmd_operator_i  = v.op;
    step();
    cmd_valid_i = 1'b0;
    chk32("level_after_push", 32'(fifo_level_o), 32'd1);
    chk1("opv_after_n", op_valid_o, 1'b0);
    step();
    chk1("opv_after_n1", op_valid_o, 1'b0);
    chk32("level_after_pop", 32'(fifo_level_o), 32'd0);
    step();
    chk1("opv_after_n2", op_valid_o, 1'b1);
    chk32("operand_a", operand_a_o, v.a);
    chk32("operand_b", operand_b_o, v.b);
    chk32("operator", 32'(operator_o), 32'(v.op));
    w = 0;
    while (op_valid_o && w < 200) begin
      w++;
      step();
    end
    chk32("opv_width", 32'(w), 32'(v.exp_width));
    chk1("rsp_valid", rsp_valid_o, 1'b1);
    chk32("rsp_result", rsp_result_o, v.exp_res);
    chk1("rsp_timeout", rsp_timeout_o, v.exp_tmo);
  endtask

  task automatic release_rsp();
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk1("rsp_dropped", rsp_valid_o, 1'b0);
  endtask

  // Per-cycle model update for random traffic; call right after driving inputs.
  task automatic model_cycle();
    mcmd_t       e;
    logic        tmo;
    logic [31:0] er;
    chk1("op_rsp_exclusive", op_valid_o && rsp_valid_o, 1'b0);
    chk1("ready_vs_level", cmd_ready_o, fifo_level_o < 3'(DEPTH));
    if (rsp_valid_o && rsp_ready_i) begin
      if (mq.size() == 0) begin
        chk1("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        e   = mq.pop_front();
        tmo = (lat_of(e.a) == 0);
        er  = tmo ? 32'h0 : alu_fn(e.a, e.b, e.op);
        chk32("rand_result", rsp_result_o, er);
        chk1("rand_timeout", rsp_timeout_o, tmo);
      end
    end
    if (cmd_valid_i && cmd_ready_o) mq.push_back('{cmd_operand_a_i, cmd_operand_b_i, cmd_operator_i});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    vec_t        v2;
    mcmd_t       fill [6];
    int          n;
    int          bad;
    logic [31:0] exp_r;

    vecs[0] = '{32'h5,         32'h3,         8'h01, 3, 32'h8,         1'b0, 3};
    vecs[1] = '{32'hFFFF_0000, 32'h0000_FFFF, 8'h04, 1, 32'hFFFF_FFFF, 1'b0, 1};
    vecs[2] = '{32'h10,        32'h3,         8'h02, 2, 32'hD,         1'b0, 2};
    vecs[3] = '{32'h0,         32'h1,         8'h02, 4, 32'hFFFF_FFFF, 1'b0, 4};
    vecs[4] = '{32'hF0F0,      32'hFF00,      8'h03, 5, 32'hF000,      1'b0, 5};
    vecs[5] = '{32'h7FFF_FFFF, 32'h1,         8'h01, 1, 32'h8000_0000, 1'b0, 1};
    vecs[6] = '{32'h1234,      32'h5678,      8'h01, 0, 32'h0,         1'b1, TMO};
    vecs[7] = '{32'hA5,        32'h5A,        8'h07, 2, 32'hFF,        1'b0, 2};

    rst_n           = 1'b0;
    cmd_valid_i     = 1'b0;
    cmd_operand_a_i = '0;
    cmd_operand_b_i = '0;
    cmd_operator_i  = '0;
    rsp_ready_i     = 1'b0;
    step();
    step();
    chk1("rst_cmd_ready", cmd_ready_o, 1'b0);
    chk1("rst_op_valid", op_valid_o, 1'b0);
    chk32("rst_operand_a", operand_a_o, 32'h0);
    chk32("rst_operand_b", operand_b_o, 32'h0);
    chk32("rst_operator", 32'(operator_o), 32'h0);
    chk1("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk32("rst_rsp_result", rsp_result_o, 32'h0);
    chk1("rst_rsp_timeout", rsp_timeout_o, 1'b0);
    chk32("rst_level", 32'(fifo_level_o), 32'h0);
    rst_n = 1'b1;
    step();
    chk1("cmd_ready_after_rst", cmd_ready_o, 1'b1);

    for (int i = 0; i < 8; i++) begin
      issue_one(vecs[i]);
      release_rsp();
    end

    // Timeout followed by late done pulses that must be ignored.
    v = '{32'hCAFE, 32'h1, 8'h01, 0, 32'h0, 1'b1, TMO};
    issue_one(v);
    late_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("late_rsp_valid", rsp_valid_o, 1'b1);
      chk32("late_rsp_result", rsp_result_o, 32'h0);
      chk1("late_rsp_timeout", rsp_timeout_o, 1'b1);
      chk1("late_op_valid", op_valid_o, 1'b0);
    end
    release_rsp();
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("late_idle_rsp", rsp_valid_o, 1'b0);
      chk1("late_idle_opv", op_valid_o, 1'b0);
    end
    late_done = 1'b0;
    step();

    // Backpressure with a second command waiting behind the held response.
    v  = '{32'h21, 32'h2, 8'h01, 2, 32'h23, 1'b0, 2};
    v2 = '{32'h40, 32'h4, 8'h02, 3, 32'h3C, 1'b0, 3};
    issue_one(v);
    cmd_valid_i     = 1'b1;
    cmd_operand_a_i = v2.a;
    cmd_operand_b_i = v2.b;
    cmd_operator_i  = v2.op;
    step();
    cmd_valid_i = 1'b0;
    fixed_lat   = v2.lat;
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("bp_rsp_valid", rsp_valid_o, 1'b1);
      chk32("bp_rsp_result", rsp_result_o, v.exp_res);
      chk1("bp_op_valid", op_valid_o, 1'b0);
      chk32("bp_level", 32'(fifo_level_o), 32'd1);
    end
    release_rsp();
    chk1("b2b_opv_after_r", op_valid_o, 1'b0);
    step();
    chk1("b2b_opv_after_r1", op_valid_o, 1'b0);
    step();
    chk1("b2b_opv_after_r2", op_valid_o, 1'b1);
    chk32("b2b_operand_a", operand_a_o, v2.a);
    n = 0;
    while (op_valid_o && n < 200) begin
      n++;
      step();
    end
    chk32("b2b_width", 32'(n), 32'(v2.exp_width));
    chk32("b2b_result", rsp_result_o, v2.exp_res);
    release_rsp();

    // Fill the FIFO behind a stalled ALU, then drain in order.
    fixed_lat   = 0;
    rsp_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) fill[k] = '{32'(k * 17 + 3), 32'(k + 1), 8'(k % 5 + 1)};
    for (int k = 0; k < 4; k++) begin
      cmd_valid_i     = 1'b1;
      cmd_operand_a_i = fill[k].a;
      cmd_operand_b_i = fill[k].b;
      cmd_operator_i  = fill[k].op;
      step();
    end
    chk32("fill_level3", 32'(fifo_level_o), 32'd3);
    chk1("fill_ready_at3", cmd_ready_o, 1'b1);
    cmd_operand_a_i = fill[4].a;
    cmd_operand_b_i = fill[4].b;
    cmd_operator_i  = fill[4].op;
    step();
    chk32("fill_level4", 32'(fifo_level_o), 32'd4);
    chk1("fill_ready_full", cmd_ready_o, 1'b0);
    cmd_operand_a_i = fill[5].a;
    cmd_operand_b_i = fill[5].b;
    cmd_operator_i  = fill[5].op;
    for (int i = 0; i < 3; i++) begin
      step();
      chk32("full_level_hold", 32'(fifo_level_o), 32'd4);
      chk1("full_ready_hold", cmd_ready_o, 1'b0);
    end
    cmd_valid_i = 1'b0;
    fixed_lat   = 2;
    rsp_ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 500 && n < 5; c++) begin
      step();
      if (rsp_valid_o) begin
        exp_r = alu_fn(fill[n].a, fill[n].b, fill[n].op);
        chk32("drain_order", rsp_result_o, exp_r);
        chk1("drain_timeout", rsp_timeout_o, 1'b0);
        n++;
      end
    end
    chk32("drain_count", 32'(n), 32'd5);
    step();
    step();
    chk1("drain_no_sixth", rsp_valid_o || op_valid_o, 1'b0);
    rsp_ready_i = 1'b0;

    // Reset while an operation is in flight with two commands queued.
    fixed_lat = 0;
    for (int k = 0; k < 3; k++) begin
      cmd_valid_i     = 1'b1;
      cmd_operand_a_i = 32'(k + 100);
      cmd_operand_b_i = 32'h1;
      cmd_operator_i  = 8'h01;
      step();
    end
    cmd_valid_i = 1'b0;
    n = 0;
    while (!op_valid_o && n < 20) begin
      n++;
      step();
    end
    chk1("mid_opv_before", op_valid_o, 1'b1);
    chk32("mid_level_before", 32'(fifo_level_o), 32'd2);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_opv", op_valid_o, 1'b0);
    chk32("mid_rst_level", 32'(fifo_level_o), 32'd0);
    chk1("mid_rst_ready", cmd_ready_o, 1'b0);
    chk1("mid_rst_rsp", rsp_valid_o, 1'b0);
    step();
    rst_n       = 1'b1;
    fixed_lat   = 1;
    rsp_ready_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (rsp_valid_o || op_valid_o) bad++;
    end
    chk32("post_rst_quiet_cycles", 32'(bad), 32'd0);

    // Random traffic against the in-order model.
    fixed_lat = -1;
    for (int c = 0; c < 3000; c++) begin
      step();
      cmd_valid_i     = ($urandom_range(0, 2) != 0);
      cmd_operand_a_i = $urandom;
      cmd_operand_b_i = $urandom;
      cmd_operator_i  = 8'($urandom_range(0, 5));
      rsp_ready_i     = ($urandom_range(0, 3) != 0);
      model_cycle();
    end
    for (int c = 0; c < 3000 && mq.size() != 0; c++) begin
      step();
      cmd_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      model_cycle();
    end
    step();
    chk32("model_drained", 32'(mq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
